smi_flit_scale_d2: RTL
======================

// Module: smi_flit_scale_d2
// PURPOSE
//  Halves the SMI flit data width by splitting each 2*FlitWidth-byte input flit
//  into one or two FlitWidth-byte output flits, lower half first.
//  Sits directly downstream of the X2 widening path, returning wide-bus frames
//  to a narrow endpoint.
//  Frame boundaries and valid byte counts are preserved exactly.
// PARAMETERS
//  FlitWidth  4  output flit width in bytes, power of two, 1..64; input is 2*FlitWidth bytes
// PORTS
//  clk          in   1              system clock, all logic on rising edge
//  srst         in   1              reset, asynchronous, active-high
//  smiInReady   in   1              input flit valid
//  smiInEofc    in   8              input end-of-frame control
//  smiInData    in   FlitWidth*16   input flit data, byte 0 at bits [7:0]
//  smiInStop    out  1              input backpressure
//  smiOutReady  out  1              output flit valid
//  smiOutEofc   out  8              output end-of-frame control
//  smiOutData   out  FlitWidth*8    output flit data
//  smiOutStop   in   1              output backpressure
// BEHAVIOUR
//  - Transfer rule (both sides): a flit moves when Ready=1 and Stop=0 on a clock
//    edge. Ready is never withdrawn and Eofc/Data never change while Stop=1.
//  - Eofc encoding: 0 = not last. n = 1..N = last flit with n valid bytes,
//    counted from byte 0, where N is the flit width in bytes.
//    Input n > 2*FlitWidth is treated as 2*FlitWidth.
//  - Reset: smiOutReady=0, smiOutEofc=0, smiOutData=0, smiInStop=1 while srst=1,
//    FSM=EMPTY, all buffers empty.
//    smiInStop drops to 0 on the first clock after srst deasserts.
//  - Input stage: 2-entry skid buffer, so smiInStop is registered (no
//    combinational Stop->Stop path). It accepts back-to-back flits until full.
//  - Split FSM holds one wide flit W:
//    EMPTY: load W from skid, go to LOW.
//    LOW: present W[low half] to the output register.
//      Eofc 0 -> out eofc 0, go to HIGH.
//      n <= FlitWidth -> out eofc n, upper half discarded, go to EMPTY
//      (or load the next W and stay LOW).
//      n > FlitWidth -> out eofc 0, go to HIGH.
//    HIGH: present W[high half].
//      Out eofc 0 if the input eofc was 0, else n-FlitWidth.
//      Then go to EMPTY, or load the next W and go to LOW.
//  - State advances only when the output register accepts the half
//    (register empty, or its flit is taken this cycle).
//  - Output register is a single stage. Its Ready/Eofc/Data are registered.
//  - Latency: first output half is valid 2 clocks after the input transfer
//    when Stop has been low.
//  - Throughput: one narrow flit per clock. Sustained input rate is 1 wide flit
//    per 2 clocks for full flits, 1 per clock for last flits with n <= FlitWidth.
//  - No flit is dropped or duplicated under any Stop pattern, including
//    smiOutStop toggling every cycle.
//  - Simultaneous output transfer and new half ready: the output register
//    reloads in the same cycle, with no bubble.
//  - srst asserted mid-frame: the partial frame is discarded, all state clears
//    immediately, and no half-flit is emitted after reset.
// CONFIGURATION
//  SMI_FLIT_SCALE_D2_ZERO_FILL_EN
//   Defined: bytes at index >= eofc in a last output flit are forced to 0x00.
//   Undefined: those bytes pass through unmodified from the input.
//   All other behaviour is identical in both builds.
// TESTING
//  1. FlitWidth=4, wide flit data=0x8877665544332211, eofc=0, then eofc=8
//     -> out 0x44332211/0, 0x88776655/0, 0x44332211/0, 0x88776655/4.
//  2. Last flit eofc=3, data=0x8877665544332211
//     -> single out flit eofc=3. Data 0x44332211 without ZERO_FILL,
//     0x00332211 with it.
//  3. Last flit eofc=6 -> out 0x44332211/eofc 0, then 0x88776655/eofc 2
//     (0x00006655 with ZERO_FILL).
//  4. 16 back-to-back wide flits, smiOutStop random 50%
//     -> 32 ordered narrow flits, output held stable during every Stop cycle,
//     and smiInStop asserts within 1 clock of the skid filling.
//  5. Assert srst for 1 clock while in state HIGH with output valid
//     -> smiOutReady=0 immediately. The next frame after reset emits its own
//     data only, with no stale upper half.

Source files
------------

// File: rtl/smi_flit_scale_d2_if.sv
// SMI flit bus bundle for the 2:1 width reducer: wide input side plus narrow output side.
interface smi_flit_scale_d2_if #(parameter int FlitWidth = 4);
  logic                    smiInReady;
  logic [7:0]              smiInEofc;
  logic [FlitWidth*16-1:0] smiInData;
  logic                    smiInStop;
  logic                    smiOutReady;
  logic [7:0]              smiOutEofc;
  logic [FlitWidth*8-1:0]  smiOutData;
  logic                    smiOutStop;

  modport master (
    output smiInReady, smiInEofc, smiInData, smiOutStop,
    input  smiInStop, smiOutReady, smiOutEofc, smiOutData
  );

  modport slave (
    input  smiInReady, smiInEofc, smiInData, smiOutStop,
    output smiInStop, smiOutReady, smiOutEofc, smiOutData
  );
endinterface

// File: rtl/smi_flit_scale_d2.sv
// Splits each 2*FlitWidth-byte SMI flit into one or two FlitWidth-byte flits, lower half first.
// Optional build macro SMI_FLIT_SCALE_D2_ZERO_FILL_EN zeroes bytes past eofc in last output flits.
module smi_flit_scale_d2 #(
  parameter int FlitWidth = 4
) (
  input logic                clk,
  input logic                srst,
  smi_flit_scale_d2_if.slave smi
);

  localparam int         NarrowBits  = FlitWidth * 8;
  localparam int         WideBits    = FlitWidth * 16;
  localparam logic [7:0] NarrowBytes = 8'(FlitWidth);
  localparam logic [7:0] WideBytes   = 8'(2 * FlitWidth);

  typedef enum logic [1:0] {EMPTY, LOW, HIGH} state_t;

  state_t                state_q, state_d;
  logic [WideBits-1:0]   skid_data_q [2];
  logic [WideBits-1:0]   skid_data_d [2];
  logic [7:0]            skid_eofc_q [2];
  logic [7:0]            skid_eofc_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  in_stop_q, in_stop_d;
  logic [WideBits-1:0]   w_data_q, w_data_d;
  logic [7:0]            w_eofc_q, w_eofc_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_eofc_q, out_eofc_d;
  logic [NarrowBits-1:0] out_data_q, out_data_d;

  logic                  push, pop, out_accept, out_load;
  logic [7:0]            in_eofc_clamped, half_eofc;
  logic [NarrowBits-1:0] half_data, half_data_filled;

  // Two-entry skid: Stop is the registered "full" flag, so upstream may have one flit in flight.
  always_comb begin
    push            = smi.smiInReady && !in_stop_q;
    in_eofc_clamped = (smi.smiInEofc > WideBytes) ? WideBytes : smi.smiInEofc;
    skid_data_d     = skid_data_q;
    skid_eofc_d     = skid_eofc_q;
    if (push) begin
      skid_data_d[wr_ptr_q] = smi.smiInData;
      skid_eofc_d[wr_ptr_q] = in_eofc_clamped;
    end
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    in_stop_d = (count_d == 2'd2);
  end

  assign out_accept = !out_valid_q || !smi.smiOutStop;

  always_comb begin
    state_d   = state_q;
    w_data_d  = w_data_q;
    w_eofc_d  = w_eofc_q;
    pop       = 1'b0;
    out_load  = 1'b0;
    half_data = '0;
    half_eofc = '0;
    unique case (state_q)
      EMPTY: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (out_accept) begin
          out_load  = 1'b1;
          half_data = w_data_q[NarrowBits-1:0];
          if (w_eofc_q != 8'd0 && w_eofc_q <= NarrowBytes) begin
            half_eofc = w_eofc_q;
            pop       = (count_q != 2'd0);
            if (pop) state_d = LOW;
            else     state_d = EMPTY;
          end else begin
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (out_accept) begin
          out_load  = 1'b1;
          half_data = w_data_q[WideBits-1:NarrowBits];
          half_eofc = (w_eofc_q == 8'd0) ? 8'd0 : (w_eofc_q - NarrowBytes);
          pop       = (count_q != 2'd0);
          if (pop) state_d = LOW;
          else     state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Loading the next wide flit in the same cycle the last half leaves avoids a bubble.
    if (pop) begin
      w_data_d = skid_data_q[rd_ptr_q];
      w_eofc_d = skid_eofc_q[rd_ptr_q];
    end
  end

  always_comb begin
    half_data_filled = half_data;
`ifdef SMI_FLIT_SCALE_D2_ZERO_FILL_EN
    for (int i = 0; i < FlitWidth; i++) begin
      if (half_eofc != 8'd0 && 8'(i) >= half_eofc) half_data_filled[i*8 +: 8] = 8'h00;
    end
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_eofc_d  = out_eofc_q;
    out_data_d  = out_data_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_eofc_d  = half_eofc;
      out_data_d  = half_data_filled;
    end else if (out_valid_q && !smi.smiOutStop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= EMPTY;
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= '0;
        skid_eofc_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_stop_q   <= 1'b1;
      w_data_q    <= '0;
      w_eofc_q    <= '0;
      out_valid_q <= 1'b0;
      out_eofc_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      skid_data_q <= skid_data_d;
      skid_eofc_q <= skid_eofc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_stop_q   <= in_stop_d;
      w_data_q    <= w_data_d;
      w_eofc_q    <= w_eofc_d;
      out_valid_q <= out_valid_d;
      out_eofc_q  <= out_eofc_d;
      out_data_q  <= out_data_d;
    end
  end

  assign smi.smiInStop   = in_stop_q;
  assign smi.smiOutReady = out_valid_q;
  assign smi.smiOutEofc  = out_eofc_q;
  assign smi.smiOutData  = out_data_q;

endmodule
